// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings and parameter limits for the IF/EX data-memory port arbiter.
package dmem_port_arbiter_pkg;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_EX = 1'b1;

   typedef enum logic {
      EX_PRI   = 1'b0,
      IF_FORCE = 1'b1
   } arb_mode_e;

   localparam int RD_LAT_MIN     = 1;
   localparam int RD_LAT_MAX     = 4;
   localparam int STARVE_MAX_MIN = 1;
   localparam int STARVE_MAX_MAX = 15;
   localparam int STARVE_CNT_W   = 4;

   function automatic int clamp_int(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

endpackage

// File: rtl/dmem_rsp_tag_pipe.sv
// DEPTH-stage {valid, owner} shift register that lines each read issue up with
// the SRAM data returning DEPTH cycles later.
module dmem_rsp_tag_pipe #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic push_valid_i,
   input  logic push_owner_i,
   output logic pop_valid_o,
   output logic pop_owner_o
);

   logic stage_valid_q [DEPTH];
   logic stage_owner_q [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stage_valid_q[gi] <= 1'b0;
               stage_owner_q[gi] <= 1'b0;
            end else begin
               stage_valid_q[gi] <= push_valid_i;
               stage_owner_q[gi] <= push_owner_i;
            end
         end
      end else begin : g_body
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stage_valid_q[gi] <= 1'b0;
               stage_owner_q[gi] <= 1'b0;
            end else begin
               stage_valid_q[gi] <= stage_valid_q[gi-1];
               stage_owner_q[gi] <= stage_owner_q[gi-1];
            end
         end
      end
   end

   assign pop_valid_o = stage_valid_q[DEPTH-1];
   assign pop_owner_o = stage_owner_q[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one SRAM port between IF (reads) and EX (loads/stores), EX priority with
// an IF starvation guard. Define DMEM_ARB_PERF_EN to add saturating perf counters.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        ex_req,
   input  logic [31:0] ex_addr,
   input  logic [3:0]  ex_re,
   input  logic [3:0]  ex_we,
   input  logic [31:0] ex_wdata,
   output logic        ex_ready,
   output logic        ex_rvalid,
   output logic [31:0] ex_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0] perf_conflict_cnt,
   output logic [31:0] perf_force_cnt
`endif
);

   localparam int LAT  = clamp_int(RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
   localparam int SMAX = clamp_int(STARVE_MAX, STARVE_MAX_MIN, STARVE_MAX_MAX);
   localparam logic [STARVE_CNT_W-1:0] STARVE_LAST = STARVE_CNT_W'(SMAX - 1);

   arb_mode_e                mode_q, mode_d;
   logic [STARVE_CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic                     conflict, grant_if, grant_ex;
   logic                     ex_write, ex_read, rd_issue, rd_owner;
   logic                     tag_valid, tag_owner;

   assign conflict = if_req & ex_req;

   // Grants are gated by rst so nothing is accepted while reset is held.
   always_comb begin
      grant_if     = 1'b0;
      grant_ex     = 1'b0;
      mode_d       = mode_q;
      starve_cnt_d = starve_cnt_q;
      if (!rst) begin
         case (mode_q)
            EX_PRI: begin
               grant_ex = ex_req;
               grant_if = if_req & ~ex_req;
               if (conflict) begin
                  if (starve_cnt_q == STARVE_LAST) begin
                     mode_d       = IF_FORCE;
                     starve_cnt_d = '0;
                  end else begin
                     starve_cnt_d = starve_cnt_q + 1'b1;
                  end
               end else begin
                  starve_cnt_d = '0;
               end
            end
            IF_FORCE: begin
               grant_if     = if_req;
               mode_d       = EX_PRI;
               starve_cnt_d = '0;
            end
            default: mode_d = EX_PRI;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q       <= EX_PRI;
         starve_cnt_q <= '0;
      end else begin
         mode_q       <= mode_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // A write takes precedence over read strobes; an EX request with no strobes
   // is accepted without touching the SRAM.
   assign ex_write   = |ex_we;
   assign ex_read    = ~ex_write & (|ex_re);

   assign if_ready   = grant_if;
   assign ex_ready   = grant_ex;
   assign sram_en    = grant_if | (grant_ex & (ex_write | ex_read));
   assign sram_we    = grant_ex ? ex_we : 4'b0000;
   assign sram_addr  = grant_if ? if_addr : ex_addr;
   assign sram_wdata = ex_wdata;

   assign rd_issue   = grant_if | (grant_ex & ex_read);
   assign rd_owner   = grant_ex ? OWN_EX : OWN_IF;

   dmem_rsp_tag_pipe #(
      .DEPTH(LAT)
   ) u_tag_pipe (
      .clk         (clk),
      .rst         (rst),
      .push_valid_i(rd_issue),
      .push_owner_i(rd_owner),
      .pop_valid_o (tag_valid),
      .pop_owner_o (tag_owner)
   );

   assign if_rvalid = tag_valid & (tag_owner == OWN_IF);
   assign ex_rvalid = tag_valid & (tag_owner == OWN_EX);
   assign if_rdata  = sram_rdata;
   assign ex_rdata  = sram_rdata;

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_conflict_q, perf_force_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_conflict_q <= '0;
         perf_force_q    <= '0;
      end else begin
         if (conflict && (perf_conflict_q != 32'hFFFF_FFFF))
            perf_conflict_q <= perf_conflict_q + 32'd1;
         if ((mode_q == EX_PRI) && (mode_d == IF_FORCE) && (perf_force_q != 32'hFFFF_FFFF))
            perf_force_q <= perf_force_q + 32'd1;
      end
   end

   assign perf_conflict_cnt = perf_conflict_q;
   assign perf_force_cnt    = perf_force_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: two arbiters (RD_LAT=1 and RD_LAT=3) driven by the same stimulus.
module tb_dmem_port_arbiter;
   import dmem_port_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, ex_req;
   logic [31:0] if_addr, ex_addr, ex_wdata, sram_rdata;
   logic [3:0]  ex_re, ex_we;

   logic        a_if_ready, a_if_rvalid, a_ex_ready, a_ex_rvalid, a_sram_en;
   logic [31:0] a_if_rdata, a_ex_rdata, a_sram_addr, a_sram_wdata;
   logic [3:0]  a_sram_we;
   logic        b_if_ready, b_if_rvalid, b_ex_ready, b_ex_rvalid, b_sram_en;
   logic [31:0] b_if_rdata, b_ex_rdata, b_sram_addr, b_sram_wdata;
   logic [3:0]  b_sram_we;
`ifdef DMEM_ARB_PERF_EN
   logic [31:0] a_perf_conflict, a_perf_force, b_perf_conflict, b_perf_force;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_a (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(a_if_ready),
      .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .ex_req(ex_req), .ex_addr(ex_addr), .ex_re(ex_re), .ex_we(ex_we),
      .ex_wdata(ex_wdata), .ex_ready(a_ex_ready), .ex_rvalid(a_ex_rvalid),
      .ex_rdata(a_ex_rdata),
      .sram_en(a_sram_en), .sram_we(a_sram_we), .sram_addr(a_sram_addr),
      .sram_wdata(a_sram_wdata), .sram_rdata(sram_rdata)
`ifdef DMEM_ARB_PERF_EN
      , .perf_conflict_cnt(a_perf_conflict), .perf_force_cnt(a_perf_force)
`endif
   );

   dmem_port_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u_b (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(b_if_ready),
      .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .ex_req(ex_req), .ex_addr(ex_addr), .ex_re(ex_re), .ex_we(ex_we),
      .ex_wdata(ex_wdata), .ex_ready(b_ex_ready), .ex_rvalid(b_ex_rvalid),
      .ex_rdata(b_ex_rdata),
      .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr),
      .sram_wdata(b_sram_wdata), .sram_rdata(sram_rdata)
`ifdef DMEM_ARB_PERF_EN
      , .perf_conflict_cnt(b_perf_conflict), .perf_force_cnt(b_perf_force)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; ex_req = 1'b0; ex_re = 4'h0; ex_we = 4'h0;
   endtask

   initial begin
      rst = 1'b1; idle_inputs();
      if_addr = '0; ex_addr = '0; ex_wdata = '0; sram_rdata = '0;
      step(); step();

      // requests during reset must not be granted
      if_req = 1'b1; ex_req = 1'b1; ex_re = 4'hF; #1;
      chk("rst_if_ready", a_if_ready, 0);
      chk("rst_ex_ready", a_ex_ready, 0);
      chk("rst_sram_en", a_sram_en, 0);
      chk("rst_sram_we", a_sram_we, 0);
      chk("rst_rvalid", a_if_rvalid | a_ex_rvalid | b_if_rvalid | b_ex_rvalid, 0);
      idle_inputs(); rst = 1'b0;
      step();

      // EX load
      ex_req = 1'b1; ex_addr = 32'h100; ex_re = 4'hF; #1;
      chk("ld_ex_ready", a_ex_ready, 1);
      chk("ld_if_ready", a_if_ready, 0);
      chk("ld_sram_en", a_sram_en, 1);
      chk("ld_sram_we", a_sram_we, 0);
      chk("ld_sram_addr", a_sram_addr, 32'h100);
      step();
      idle_inputs(); sram_rdata = 32'hCAFE_0001; #1;
      chk("ld_a_ex_rvalid", a_ex_rvalid, 1);
      chk("ld_a_ex_rdata", a_ex_rdata, 32'hCAFE_0001);
      chk("ld_a_if_rvalid", a_if_rvalid, 0);
      chk("ld_b_early", b_ex_rvalid, 0);
      step();
      chk("ld_a_one_shot", a_ex_rvalid, 0);
      step();
      chk("ld_b_ex_rvalid", b_ex_rvalid, 1);
      chk("ld_b_if_rvalid", b_if_rvalid, 0);
      step();

      // sustained contention: EX x4, IF, EX
      for (int i = 0; i < 6; i++) begin
         if_req = 1'b1; ex_req = 1'b1; ex_re = 4'hF;
         if_addr = 32'h200; ex_addr = 32'h300; #1;
         chk($sformatf("starve_if_ready_%0d", i), a_if_ready, (i == 4) ? 1 : 0);
         chk($sformatf("starve_ex_ready_%0d", i), a_ex_ready, (i == 4) ? 0 : 1);
         chk($sformatf("starve_b_if_ready_%0d", i), b_if_ready, (i == 4) ? 1 : 0);
         if (i == 4) chk("force_sram_addr", a_sram_addr, 32'h200);
`ifdef DMEM_ARB_PERF_EN
         if (i == 5) begin
            chk("perf_conflict", a_perf_conflict, 5);
            chk("perf_force", a_perf_force, 1);
            chk("perf_b_conflict", b_perf_conflict, 5);
            chk("perf_b_force", b_perf_force, 1);
         end
`endif
         step();
      end
      idle_inputs();
      repeat (4) step();

      // EX store: read strobes ignored, no response
      ex_req = 1'b1; ex_addr = 32'h80; ex_we = 4'b0011; ex_re = 4'hF;
      ex_wdata = 32'hDEAD_BEEF; #1;
      chk("st_ex_ready", a_ex_ready, 1);
      chk("st_sram_en", a_sram_en, 1);
      chk("st_sram_we", a_sram_we, 32'h3);
      chk("st_sram_wdata", a_sram_wdata, 32'hDEAD_BEEF);
      chk("st_b_sram", {b_sram_en, b_sram_we, b_sram_wdata[15:0]}, {1'b1, 4'b0011, 16'hBEEF});
      step();
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("st_no_rvalid_%0d", k), {a_ex_rvalid, b_ex_rvalid}, 0);
         step();
      end

      // alternating owners through the 3-deep tag pipe
      if_req = 1'b1; if_addr = 32'h0; #1;
      chk("alt0_b_if_ready", b_if_ready, 1);
      chk("alt0_b_addr", b_sram_addr, 32'h0);
      step();
      if_req = 1'b0; ex_req = 1'b1; ex_addr = 32'h40; ex_re = 4'hF;
      sram_rdata = 32'h3333_3333; #1;
      chk("alt1_b_ex_ready", b_ex_ready, 1);
      chk("alt1_b_addr", b_sram_addr, 32'h40);
      chk("alt1_a_if_rvalid", a_if_rvalid, 1);
      chk("alt1_a_if_rdata", a_if_rdata, 32'h3333_3333);
      step();
      ex_req = 1'b0; ex_re = 4'h0; if_req = 1'b1; if_addr = 32'h4; #1;
      chk("alt2_b_if_ready", b_if_ready, 1);
      chk("alt2_a_ex_rvalid", a_ex_rvalid, 1);
      step();
      if_req = 1'b0; sram_rdata = 32'h1111_1111; #1;
      chk("alt3_b_rvalid", {b_if_rvalid, b_ex_rvalid}, 2'b10);
      chk("alt3_b_if_rdata", b_if_rdata, 32'h1111_1111);
      step();
      sram_rdata = 32'h2222_2222; #1;
      chk("alt4_b_rvalid", {b_if_rvalid, b_ex_rvalid}, 2'b01);
      chk("alt4_b_ex_rdata", b_ex_rdata, 32'h2222_2222);
      step();
      chk("alt5_b_rvalid", {b_if_rvalid, b_ex_rvalid}, 2'b10);
      step();

      // reset with reads in flight
      if_req = 1'b1; if_addr = 32'h8; #1;
      chk("rs_if_ready", a_if_ready, 1);
      step();
      ex_req = 1'b1; ex_re = 4'hF; #1;
      chk("rs_ex_wins", {a_if_ready, a_ex_ready}, 2'b01);
      step();
      chk("rs_starve_cnt", u_a.starve_cnt_q, 1);
      step();
      chk("rs_b_if_pending", b_if_rvalid, 1);
      rst = 1'b1; idle_inputs(); #1;
      chk("rs_b_if_dropped", b_if_rvalid, 0);
      chk("rs_a_ex_dropped", a_ex_rvalid, 0);
      chk("rs_starve_clr", u_a.starve_cnt_q, 0);
      step();
      rst = 1'b0; #1;
      chk("rs_mode", u_a.mode_q, EX_PRI);
      chk("rs_b_starve", u_b.starve_cnt_q, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("rs_quiet_%0d", k), {b_if_rvalid, b_ex_rvalid, a_if_rvalid, a_ex_rvalid}, 0);
      end

      // EX with no strobes
      ex_req = 1'b1; ex_re = 4'h0; ex_we = 4'h0; #1;
      chk("nop_ex_ready", a_ex_ready, 1);
      chk("nop_sram_en", a_sram_en, 0);
      step();
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("nop_no_rvalid_%0d", k), {a_ex_rvalid, b_ex_rvalid}, 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single synchronous data/instruction SRAM port between two requesters: the fetch stage (IF, read-only) and the execute stage (EX, load/store; 4-bit byte strobes).
- Arbitrates each cycle with EX priority and a starvation guard for IF.
- Tracks in-flight reads through a tag pipeline so each read response returns to its owner.
- Sits between the IF/EX stages and the SRAM macro.

Parameters:
- RD_LAT, 1, SRAM read latency in cycles; legal 1..4.
- STARVE_MAX, 4, consecutive IF-denied cycles that force the next grant to IF; legal 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  IF read request; held with if_addr until if_ready
- if_addr  in  32  IF word address
- if_ready  out  1  IF request accepted this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  32  IF read data
- ex_req  in  1  EX request; held with its fields until ex_ready
- ex_addr  in  32  EX address
- ex_re  in  4  EX read strobes
- ex_we  in  4  EX write strobes
- ex_wdata  in  32  EX write data
- ex_ready  out  1  EX request accepted this cycle
- ex_rvalid  out  1  EX load data valid
- ex_rdata  out  32  EX load data
- sram_en  out  1  SRAM access enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid RD_LAT cycles after a read issue

Behaviour:
- Mode FSM, 2 states, reset state EX_PRI:
  - EX_PRI: on conflict (if_req and ex_req both high), EX wins and starve_cnt increments. starve_cnt clears on any IF grant and on a cycle with if_req low. When starve_cnt == STARVE_MAX-1 and IF is denied again, go to IF_FORCE.
  - IF_FORCE: if_req granted unconditionally and EX stalled. Return to EX_PRI after one IF grant, clearing starve_cnt. If if_req drops while in IF_FORCE, return to EX_PRI with no grant.
- Grant is combinational in the request cycle:
  - if_ready = grant_if, ex_ready = grant_ex; at most one high per cycle.
  - No request: sram_en=0, sram_we=0; sram_addr and sram_wdata don't-care.
- Issue:
  - Granted IF: sram_en=1, sram_we=0, sram_addr=if_addr.
  - Granted EX: sram_en=1, sram_addr=ex_addr, sram_wdata=ex_wdata.
  - EX with ex_we nonzero: write, sram_we=ex_we, no response, ex_re ignored.
  - EX with ex_we=0 and ex_re nonzero: read, sram_we=0.
  - EX with ex_we=0 and ex_re=0: accepted, sram_en=0, no response.
- Response routing:
  - Tag pipeline, RD_LAT stages of {valid, owner}, shifts every cycle.
  - A read issue pushes {1, IF|EX}; any other cycle pushes {0, x}.
  - if_rvalid = tag_out.valid & owner==IF; ex_rvalid = tag_out.valid & owner==EX.
  - if_rdata = ex_rdata = sram_rdata (unregistered); consumers qualify with rvalid.
  - Throughput: one access per cycle; back-to-back reads from alternating owners return in issue order.
- Reset, asynchronous at any time:
  - FSM to EX_PRI, starve_cnt=0, all tag valids 0.
  - if_rvalid=ex_rvalid=0 immediately; in-flight reads are dropped and never produce rvalid.
  - While rst is high: if_ready=ex_ready=0, sram_en=0, sram_we=0.
- Boundary cases:
  - A requester that drops req without ready is a protocol error; the block is not required to handle it.
  - Simultaneous grant issue and tag-out on the same cycle is normal pipelining; no stall.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined: adds outputs perf_conflict_cnt (32) and perf_force_cnt (32).
  - perf_conflict_cnt increments on each cycle with both requests high.
  - perf_force_cnt increments on each entry to IF_FORCE.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package:
  - owner encoding (OWN_IF=1'b0, OWN_EX=1'b1)
  - mode FSM state encoding (EX_PRI, IF_FORCE)
  - RD_LAT and STARVE_MAX legal-range constants
- One natural sub-module: dmem_rsp_tag_pipe, the RD_LAT-deep {valid, owner} shift register with async reset.

Test Plan:
- EX load only, ex_addr=0x100, ex_re=4'hF, RD_LAT=1 -> ex_ready same cycle, sram_en=1, sram_we=0; next cycle ex_rvalid=1 with sram_rdata; if_rvalid=0.
- Both requests held continuously, STARVE_MAX=4 -> EX granted 4 cycles, IF granted on cycle 5, EX again on cycle 6; with DMEM_ARB_PERF_EN, perf_force_cnt=1 and perf_conflict_cnt=5 (one per contended cycle; IF_FORCE cycle counts).
- EX store, ex_we=4'b0011, ex_wdata=0xDEADBEEF -> sram_we=4'b0011, sram_wdata=0xDEADBEEF; no ex_rvalid in any following cycle.
- RD_LAT=3, alternating IF read at 0x0, EX read at 0x40, IF read at 0x4 -> rvalids at cycles 3, 4, 5, routed IF, EX, IF.
- rst asserted 1 cycle after an IF read issue with RD_LAT=2 -> if_rvalid never asserts; after rst release, state EX_PRI and starve_cnt=0.
- EX request with ex_re=0, ex_we=0 -> ex_ready=1, sram_en=0, no rvalid.
